pixel_scheduler: RTL and testbench

PIXEL_SCHEDULER -- requirements
Module: pixel_scheduler

---
 rtl/mandelbrot_pkg.sv | 24 ++
 rtl/raster_counter.sv | 54 +++++
 rtl/pixel_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_pixel_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
`default_nettype none
// ============================================================================
// mandelbrot_pkg : shared widths, raster defaults and scheduler state type
// Rev 1.0
// ============================================================================
package mandelbrot_pkg;

    localparam int C_PIXEL_DATA_WIDTH = 10;
    localparam int C_RBG_SIZE         = 24;
    localparam int C_X_SIZE           = 640;
    localparam int C_Y_SIZE           = 480;

    typedef struct packed {
        logic [C_PIXEL_DATA_WIDTH-1:0] x;
        logic [C_PIXEL_DATA_WIDTH-1:0] y;
    } pixel_coord_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
// raster_counter : x-fastest raster position with line/frame end flags
// Rev 1.0
// ============================================================================
module raster_counter
    import mandelbrot_pkg::*;
#(
    parameter int PIXEL_DATA_WIDTH = C_PIXEL_DATA_WIDTH,
    parameter int X_SIZE           = C_X_SIZE,
    parameter int Y_SIZE           = C_Y_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clr,
    input  logic                        i_inc,
    output logic [PIXEL_DATA_WIDTH-1:0] o_x,
    output logic [PIXEL_DATA_WIDTH-1:0] o_y,
    output logic                        o_last_x,
    output logic                        o_last_y
);

    localparam logic [PIXEL_DATA_WIDTH-1:0] C_X_LAST = PIXEL_DATA_WIDTH'(X_SIZE - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] C_Y_LAST = PIXEL_DATA_WIDTH'(Y_SIZE - 1);
    localparam logic [PIXEL_DATA_WIDTH-1:0] C_ONE    = {{(PIXEL_DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [PIXEL_DATA_WIDTH-1:0] r_x;
    logic [PIXEL_DATA_WIDTH-1:0] r_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clr) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_inc) begin
            if (r_x == C_X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == C_Y_LAST) ? '0 : r_y + C_ONE;
            end else begin
                r_x <= r_x + C_ONE;
            end
        end
    end

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_last_x = (r_x == C_X_LAST);
    // line-only flag; the final pixel is o_last_x && o_last_y
    assign o_last_y = (r_y == C_Y_LAST);

endmodule
`default_nettype wire

// File: rtl/pixel_scheduler.sv
`default_nettype none
// ============================================================================
// pixel_scheduler : raster dispatch to engines, in-order retire via reorder buffer
// Rev 1.0
// ============================================================================
module pixel_scheduler
    import mandelbrot_pkg::*;
#(
    parameter int NUM_ENGINES      = 8,
    parameter int PIXEL_DATA_WIDTH = C_PIXEL_DATA_WIDTH,
    parameter int X_SIZE           = C_X_SIZE,
    parameter int Y_SIZE           = C_Y_SIZE,
    parameter int ROB_DEPTH        = 16,
    parameter int RBG_SIZE         = C_RBG_SIZE
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    output logic                                    busy,
    output logic                                    frame_done,
    input  logic [NUM_ENGINES-1:0]                  eng_idle,
    output logic [NUM_ENGINES-1:0]                  eng_start,
    output logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] eng_x,
    output logic [NUM_ENGINES*PIXEL_DATA_WIDTH-1:0] eng_y,
    input  logic [NUM_ENGINES-1:0]                  res_valid,
    input  logic [NUM_ENGINES*RBG_SIZE-1:0]         res_colour,
    output logic [RBG_SIZE-1:0]                     colour_o,
    output logic                                    valid,
    input  logic                                    ready,
    output logic                                    first,
    output logic                                    last_x,
    output logic                                    last_y,
    output logic                                    proto_err
);

    localparam int         AW        = $clog2(ROB_DEPTH);
    localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

    sched_state_t                r_state;
    sched_state_t                w_state_nxt;
    logic                        w_start_acc;
    logic                        w_can_issue;
    logic                        w_retire;
    logic                        w_retire_final;

    logic [NUM_ENGINES-1:0]      r_eng_busy;
    logic [NUM_ENGINES-1:0]      r_eng_start;
    logic [AW-1:0]               r_tag   [NUM_ENGINES];
    logic [PIXEL_DATA_WIDTH-1:0] r_eng_x [NUM_ENGINES];
    logic [PIXEL_DATA_WIDTH-1:0] r_eng_y [NUM_ENGINES];

    logic [ROB_DEPTH-1:0]        r_slot_full;
    logic [RBG_SIZE-1:0]         r_slot_data [ROB_DEPTH];
    logic [AW:0]                 r_wr_ptr;
    logic [AW:0]                 r_rd_ptr;
    logic                        r_issue_done;
    logic                        r_frame_done;
    logic                        r_proto_err;

    logic [AW-1:0]               w_head;
    logic                        w_rob_full;
    logic [NUM_ENGINES-1:0]      w_cand;
    logic [NUM_ENGINES-1:0]      w_grant;
    logic                        w_dispatch;

    logic [PIXEL_DATA_WIDTH-1:0] w_iss_x, w_iss_y, w_ret_x, w_ret_y;
    logic                        w_iss_last_x, w_iss_last_y, w_ret_last_x, w_ret_last_y;

    assign w_head     = r_rd_ptr[AW-1:0];
    assign w_rob_full = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_retire       = r_slot_full[w_head] && ready;
    assign w_retire_final = w_retire && w_ret_last_x && w_ret_last_y;

    // lowest-index eligible engine wins; busy bits are registered so a
    // just-returned engine only becomes eligible on the following cycle
    assign w_cand     = eng_idle & ~r_eng_busy & {NUM_ENGINES{w_can_issue}};
    assign w_grant    = w_cand & (-w_cand);
    assign w_dispatch = |w_grant;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        w_can_issue = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_start_acc = 1'b1;
                end
            end
            S_RUN: begin
                w_can_issue = !r_issue_done && !w_rob_full;
                if (w_retire_final) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_eng_busy   <= '0;
            r_eng_start  <= '0;
            r_slot_full  <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_issue_done <= 1'b0;
            r_frame_done <= 1'b0;
            r_proto_err  <= 1'b0;
            for (int i = 0; i < NUM_ENGINES; i++) begin
                r_tag[i]   <= '0;
                r_eng_x[i] <= '0;
                r_eng_y[i] <= '0;
            end
            for (int s = 0; s < ROB_DEPTH; s++) begin
                r_slot_data[s] <= '0;
            end
        end else begin
            r_eng_start  <= w_grant;
            r_frame_done <= w_retire_final;
            r_eng_busy   <= (r_eng_busy & ~res_valid) | w_grant;

            if (w_start_acc) begin
                r_issue_done <= 1'b0;
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
            end

            for (int i = 0; i < NUM_ENGINES; i++) begin
                if (w_grant[i]) begin
                    r_eng_x[i] <= w_iss_x;
                    r_eng_y[i] <= w_iss_y;
                    r_tag[i]   <= r_wr_ptr[AW-1:0];
                end
                if (res_valid[i]) begin
                    if (r_eng_busy[i]) begin
                        r_slot_data[r_tag[i]] <= res_colour[i*RBG_SIZE +: RBG_SIZE];
                        r_slot_full[r_tag[i]] <= 1'b1;
                    end else begin
                        r_proto_err <= 1'b1;
                    end
                end
            end

            if (w_dispatch) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
                if (w_iss_last_x && w_iss_last_y) begin
                    r_issue_done <= 1'b1;
                end
            end

            // the head slot is full here, so it can never be a slot being written this cycle
            if (w_retire) begin
                r_slot_full[w_head] <= 1'b0;
                r_rd_ptr            <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    raster_counter #(
        .PIXEL_DATA_WIDTH (PIXEL_DATA_WIDTH),
        .X_SIZE           (X_SIZE),
        .Y_SIZE           (Y_SIZE)
    ) u_issue_cnt (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (w_start_acc),
        .i_inc    (w_dispatch),
        .o_x      (w_iss_x),
        .o_y      (w_iss_y),
        .o_last_x (w_iss_last_x),
        .o_last_y (w_iss_last_y)
    );

    raster_counter #(
        .PIXEL_DATA_WIDTH (PIXEL_DATA_WIDTH),
        .X_SIZE           (X_SIZE),
        .Y_SIZE           (Y_SIZE)
    ) u_retire_cnt (
        .clk      (clk),
        .rst      (reset),
        .i_clr    (w_start_acc),
        .i_inc    (w_retire),
        .o_x      (w_ret_x),
        .o_y      (w_ret_y),
        .o_last_x (w_ret_last_x),
        .o_last_y (w_ret_last_y)
    );

    generate
        for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_eng_out
            assign eng_x[g*PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH] = r_eng_x[g];
            assign eng_y[g*PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH] = r_eng_y[g];
        end
    endgenerate

    assign eng_start  = r_eng_start;
    assign busy       = (r_state == S_RUN);
    assign frame_done = r_frame_done;
    assign proto_err  = r_proto_err;
    assign valid      = r_slot_full[w_head];
    assign colour_o   = valid ? r_slot_data[w_head] : '0;
    assign first      = valid && (w_ret_x == '0) && (w_ret_y == '0);
    assign last_x     = valid && w_ret_last_x;
    assign last_y     = valid && w_ret_last_x && w_ret_last_y;

endmodule
`default_nettype wire

// File: tb/tb_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// tb_pixel_scheduler : frame scenarios against an engine model and raster-order reference
// Rev 1.0
// ============================================================================
module tb_pixel_scheduler;

    localparam int NE   = 4;
    localparam int PW   = 10;
    localparam int XS   = 4;
    localparam int YS   = 2;
    localparam int RD   = 4;
    localparam int CW   = 24;
    localparam int NPIX = XS * YS;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              busy;
    logic              frame_done;
    logic [NE-1:0]     eng_idle;
    logic [NE-1:0]     eng_start;
    logic [NE*PW-1:0]  eng_x;
    logic [NE*PW-1:0]  eng_y;
    logic [NE-1:0]     res_valid;
    logic [NE*CW-1:0]  res_colour;
    logic [CW-1:0]     colour_o;
    logic              valid;
    logic              ready;
    logic              first;
    logic              last_x;
    logic              last_y;
    logic              proto_err;

    always #5 clk = ~clk;

    pixel_scheduler #(
        .NUM_ENGINES      (NE),
        .PIXEL_DATA_WIDTH (PW),
        .X_SIZE           (XS),
        .Y_SIZE           (YS),
        .ROB_DEPTH        (RD),
        .RBG_SIZE         (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .eng_idle   (eng_idle),
        .eng_start  (eng_start),
        .eng_x      (eng_x),
        .eng_y      (eng_y),
        .res_valid  (res_valid),
        .res_colour (res_colour),
        .colour_o   (colour_o),
        .valid      (valid),
        .ready      (ready),
        .first      (first),
        .last_x     (last_x),
        .last_y     (last_y),
        .proto_err  (proto_err)
    );

    typedef struct packed {
        logic [7:0]    l0;
        logic [7:0]    l1;
        logic [7:0]    l2;
        logic [7:0]    l3;
        logic [NE-1:0] mask;
        logic [7:0]    pct;
        logic [7:0]    stall;
        logic [7:0]    exp_stall_disp;
        logic          mid_start;
        logic          start_last;
        logic [7:0]    exp_pix;
    } vec_t;

    vec_t vt [10];

    int total = 0;
    int bad   = 0;

    // engine model and reference state
    int            cnt [NE];
    int            lat [NE];
    logic [PW-1:0] ex  [NE];
    logic [PW-1:0] ey  [NE];
    logic [NE-1:0] mask;
    int            ready_pct;
    int            stall_left;
    int            salt = 0;
    int            n_ret, n_disp, n_done;
    int            cyc = 0;
    int            t_last, t_done;
    logic          busy_at_done;
    logic          hold_valid = 1'b0;
    logic [CW-1:0] hold_col;
    logic          arm_last = 1'b0;
    logic          armed_start = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CW-1:0] colour_of(input int x, input int y, input int s);
        int v;
        v = x * 7 + y * 131 + s * 4099 + 4660;
        return v[CW-1:0];
    endfunction

    task automatic step();
        int k;
        @(negedge clk);
        cyc++;
        if (armed_start) begin
            start       = 1'b0;
            armed_start = 1'b0;
        end
        n_disp += $countones(eng_start);
        if (frame_done) begin
            n_done++;
            t_done       = cyc;
            busy_at_done = busy;
        end
        if (hold_valid && valid)
            check("stall_hold", 64'(colour_o), 64'(hold_col));

        res_valid = '0;
        for (int i = 0; i < NE; i++) begin
            if (cnt[i] > 0) begin
                cnt[i]--;
                if (cnt[i] == 0) begin
                    res_valid[i]            = 1'b1;
                    res_colour[i*CW +: CW]  = colour_of(int'(ex[i]), int'(ey[i]), salt);
                end
            end
        end
        for (int i = 0; i < NE; i++) begin
            if (eng_start[i]) begin
                if (cnt[i] != 0) begin
                    total++;
                    bad++;
                    $display("FAIL double_dispatch: engine %0d restarted with %0d cycles left", i, cnt[i]);
                end
                ex[i]  = eng_x[i*PW +: PW];
                ey[i]  = eng_y[i*PW +: PW];
                cnt[i] = lat[i];
            end
        end
        for (int i = 0; i < NE; i++)
            eng_idle[i] = mask[i] && (cnt[i] == 0);

        if (stall_left > 0) begin
            ready = 1'b0;
            stall_left--;
        end else begin
            ready = ($urandom_range(99) < ready_pct);
        end

        if (valid && ready) begin
            k = n_ret;
            check("pixel", {37'd0, colour_o, first, last_x, last_y},
                  {37'd0, colour_of(k % XS, k / XS, salt), k == 0, (k % XS) == XS - 1, k == NPIX - 1});
            if (k == NPIX - 1) begin
                t_last = cyc;
                if (arm_last) begin
                    start       = 1'b1;
                    armed_start = 1'b1;
                end
            end
            n_ret++;
            hold_valid = 1'b0;
        end else begin
            hold_valid = valid;
            hold_col   = colour_o;
        end
    endtask

    task automatic run_frame(input vec_t v);
        int guard;
        lat[0]     = int'(v.l0);
        lat[1]     = int'(v.l1);
        lat[2]     = int'(v.l2);
        lat[3]     = int'(v.l3);
        mask       = v.mask;
        ready_pct  = int'(v.pct);
        stall_left = int'(v.stall);
        arm_last   = v.start_last;
        salt++;
        n_ret = 0; n_done = 0; n_disp = 0;
        t_last = -1; t_done = -2; busy_at_done = 1'b1;

        start = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);

        if (v.stall != 8'd0) begin
            guard = 0;
            while (stall_left > 0 && guard < 300) begin
                step();
                guard++;
            end
            check("dispatches_while_stalled", 64'(n_disp), 64'(v.exp_stall_disp));
        end

        if (v.mid_start) begin
            repeat (3) step();
            start = 1'b1;
            step();
            start = 1'b0;
        end

        guard = 0;
        while (n_done == 0 && guard < 3000) begin
            step();
            guard++;
        end
        check("frame_done_seen", 64'(n_done), 64'd1);
        check("done_timing", 64'(t_done - t_last), 64'd1);
        check("busy_at_done", 64'(busy_at_done), 64'd0);
        repeat (3) step();
        arm_last = 1'b0;
        check("pixels_retired", 64'(n_ret), 64'(v.exp_pix));
        check("done_once", 64'(n_done), 64'd1);
        check("dispatch_total", 64'(n_disp), 64'(NPIX));
        check("idle_after_frame", 64'(busy), 64'd0);
        check("no_proto_err", 64'(proto_err), 64'd0);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        res_valid  = '0;
        hold_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        // l0,l1,l2,l3 latencies; mask of engines that ever report idle
        vt[0] = '{l0:8'd3,  l1:8'd3, l2:8'd1, l3:8'd1, mask:4'b0011, pct:8'd100, stall:8'd0,
                  exp_stall_disp:8'd0, mid_start:1'b0, start_last:1'b0, exp_pix:8'd8};
        vt[1] = '{l0:8'd20, l1:8'd1, l2:8'd1, l3:8'd1, mask:4'b0011, pct:8'd100, stall:8'd0,
                  exp_stall_disp:8'd0, mid_start:1'b0, start_last:1'b0, exp_pix:8'd8};
        vt[2] = '{l0:8'd2,  l1:8'd1, l2:8'd1, l3:8'd1, mask:4'b0011, pct:8'd100, stall:8'd0,
                  exp_stall_disp:8'd0, mid_start:1'b0, start_last:1'b0, exp_pix:8'd8};
        vt[3] = '{l0:8'd3,  l1:8'd3, l2:8'd3, l3:8'd3, mask:4'b1111, pct:8'd100, stall:8'd30,
                  exp_stall_disp:8'd4, mid_start:1'b0, start_last:1'b0, exp_pix:8'd8};
        vt[4] = '{l0:8'd5,  l1:8'd2, l2:8'd7, l3:8'd1, mask:4'b1111, pct:8'd50,  stall:8'd0,
                  exp_stall_disp:8'd0, mid_start:1'b1, start_last:1'b1, exp_pix:8'd8};
        for (int r = 5; r < 10; r++) begin
            vt[r].l0             = 8'($urandom_range(12, 1));
            vt[r].l1             = 8'($urandom_range(12, 1));
            vt[r].l2             = 8'($urandom_range(12, 1));
            vt[r].l3             = 8'($urandom_range(12, 1));
            vt[r].mask           = NE'($urandom_range(15, 1));
            vt[r].pct            = 8'($urandom_range(100, 30));
            vt[r].stall          = 8'd0;
            vt[r].exp_stall_disp = 8'd0;
            vt[r].mid_start      = 1'b0;
            vt[r].start_last     = 1'($urandom_range(1, 0));
            vt[r].exp_pix        = 8'd8;
        end

        reset = 1'b1; start = 1'b0; ready = 1'b0;
        eng_idle = '0; res_valid = '0; res_colour = '0;
        mask = '0; ready_pct = 100; stall_left = 0;
        for (int i = 0; i < NE; i++) begin
            cnt[i] = 0; lat[i] = 1; ex[i] = '0; ey[i] = '0;
        end

        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({busy, frame_done, valid, first, last_x, last_y, proto_err}), 64'd0);
        check("rst_eng_start", 64'(eng_start), 64'd0);
        check("rst_eng_xy", 64'({eng_x, eng_y}), 64'd0);
        check("rst_colour", 64'(colour_o), 64'd0);
        reset = 1'b0;

        for (int r = 0; r < 10; r++)
            run_frame(vt[r]);

        // stray result while idle
        step();
        res_valid[0]       = 1'b1;
        res_colour[CW-1:0] = 24'hABCDEF;
        step();
        check("spurious_proto_err", 64'(proto_err), 64'd1);
        check("spurious_valid", 64'(valid), 64'd0);
        check("spurious_colour", 64'(colour_o), 64'd0);
        do_reset();
        check("proto_err_cleared", 64'(proto_err), 64'd0);

        // reset in the middle of a frame with work outstanding
        for (int i = 0; i < NE; i++) lat[i] = 10;
        mask = 4'b1111; ready_pct = 100; stall_left = 0;
        salt++; n_ret = 0; n_disp = 0; n_done = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (n_disp < 3 && guard < 50) begin
            step();
            guard++;
        end
        check("disp_before_reset", 64'(n_disp), 64'd3);
        reset = 1'b1;
        #1;
        check("midrst_ctrl", 64'({busy, frame_done, valid, first, last_x, last_y, proto_err}), 64'd0);
        check("midrst_eng_start", 64'(eng_start), 64'd0);
        check("midrst_eng_xy", 64'({eng_x, eng_y}), 64'd0);
        check("midrst_colour", 64'(colour_o), 64'd0);
        hold_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (15) step();
        check("late_result_proto_err", 64'(proto_err), 64'd1);
        check("late_result_valid", 64'(valid), 64'd0);
        check("late_result_retired", 64'(n_ret), 64'd0);
        do_reset();
        run_frame(vt[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
